// File: rtl/regfile_mp.sv
// Multi-ported register file with zero-latency reads, optional same-cycle write forwarding
// and a self-timed sequencer that zeroes every register after reset or on request.
module regfile_mp #(
    parameter int W       = 32,
    parameter int RW      = 5,
    parameter int NR      = 2,
    parameter int NW      = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    rd_en,
    input  logic [NR*RW-1:0] rd_addr,
    output logic [NR*W-1:0]  rd_data,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*RW-1:0] wr_addr,
    input  logic [NW*W-1:0]  wr_data,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done
);

    localparam int DEPTH = 2 ** RW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    logic [RW-1:0] cnt;
    logic [W-1:0]  regs [DEPTH];

    // wr_fwd deliberately excludes clr_req so that rd_data never depends on it combinationally.
    logic [NW-1:0] wr_fwd;
    logic [NW-1:0] wr_ok;

    for (genvar j = 0; j < NW; j++) begin : g_wr
        logic r0_hit;
        assign r0_hit    = (ZERO_R0 != 0) && (wr_addr[j*RW +: RW] == '0);
        assign wr_fwd[j] = !busy && wr_en[j] && !r0_hit;
        assign wr_ok[j]  = wr_fwd[j] && !clr_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            busy     <= 1'b1;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_req) begin
                        cnt <= '0;
                    end else if (cnt == '1) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; rst only suppresses updates so an interrupted clear restarts cleanly.
    // Ascending port order lets the highest-numbered port win an address conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                regs[cnt] <= '0;
            end else begin
                for (int j = 0; j < NW; j++) begin
                    if (wr_ok[j]) begin
                        regs[wr_addr[j*RW +: RW]] <= wr_data[j*W +: W];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [RW-1:0] ra;
        logic [W-1:0]  rv;
        logic          zero_out;

        assign ra = rd_addr[i*RW +: RW];

        always_comb begin
            rv = regs[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NW; j++) begin
                    if (wr_fwd[j] && (wr_addr[j*RW +: RW] == ra)) begin
                        rv = wr_data[j*W +: W];
                    end
                end
            end
        end

        assign zero_out            = busy || !rd_en[i] || ((ZERO_R0 != 0) && (ra == '0));
        assign rd_data[i*W +: W]   = zero_out ? '0 : rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (forwarding/zero-r0 on and off) share one
// stimulus; a per-cycle reference model plus literal spot checks judge both.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        clr_req;
    logic [63:0] rd_a, rd_b;
    logic        busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int passes = 0;

    regfile_mp #(.W(32), .RW(5), .NR(2), .NW(2), .ZERO_R0(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
        .busy(busy_a), .clr_done(done_a)
    );

    regfile_mp #(.W(32), .RW(5), .NR(2), .NW(2), .ZERO_R0(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
        .busy(busy_b), .clr_done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: contents of both register files plus clear progress.
    logic [31:0] mem [2][32];
    int          m_busy;
    int          m_idx;
    int          m_done;

    function automatic logic [31:0] exp_rd(input int inst, input int i);
        logic [4:0]  a;
        logic [31:0] v;
        a = rd_addr[i*5 +: 5];
        if (!rst || m_busy != 0 || !rd_en[i]) return 32'h0;
        if (inst == 0 && a == 5'd0) return 32'h0;
        v = mem[inst][a];
        if (inst == 0) begin
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wr_addr[j*5 +: 5] == a) v = wr_data[j*32 +: 32];
        end
        return v;
    endfunction

    task automatic model_edge();
        int a;
        if (!rst) begin
            m_busy = 1; m_idx = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (m_busy != 0) begin
            mem[0][m_idx] = 32'h0;
            mem[1][m_idx] = 32'h0;
            if (clr_req) m_idx = 0;
            else if (m_idx == 31) begin m_busy = 0; m_idx = 0; m_done = 1; end
            else m_idx = m_idx + 1;
        end else if (clr_req) begin
            m_busy = 1; m_idx = 0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j]) begin
                    a = int'(wr_addr[j*5 +: 5]);
                    if (a != 0) mem[0][a] = wr_data[j*32 +: 32];
                    mem[1][a] = wr_data[j*32 +: 32];
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin mem[0][k] = 32'h0; mem[1][k] = 32'h0; end
        m_busy = 1; m_idx = 0; m_done = 0;
        forever begin
            @(negedge clk);
            chk("model_busy_a", {31'h0, busy_a}, (!rst || m_busy != 0) ? 32'h1 : 32'h0);
            chk("model_busy_b", {31'h0, busy_b}, (!rst || m_busy != 0) ? 32'h1 : 32'h0);
            chk("model_done_a", {31'h0, done_a}, (rst && m_done != 0) ? 32'h1 : 32'h0);
            chk("model_done_b", {31'h0, done_b}, (rst && m_done != 0) ? 32'h1 : 32'h0);
            chk("model_rd_a0", rd_a[31:0],  exp_rd(0, 0));
            chk("model_rd_a1", rd_a[63:32], exp_rd(0, 1));
            chk("model_rd_b0", rd_b[31:0],  exp_rd(1, 0));
            chk("model_rd_b1", rd_b[63:32], exp_rd(1, 1));
            @(posedge clk);
            model_edge();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
        rd_en = en; rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
        wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0};
    endtask

    // Counts busy cycles and clr_done pulses over the next 40 cycles.
    task automatic count_clear(input string tag);
        int bcnt, dcnt, dat;
        bcnt = 0; dcnt = 0; dat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy_a) bcnt++;
            if (done_a) begin dcnt++; dat = k; end
        end
        chk({tag, "_busy_cycles"}, bcnt, 32);
        chk({tag, "_done_count"}, dcnt, 1);
        chk({tag, "_done_cycle"}, dat, 33);
        tick();
    endtask

    initial begin
        rst = 1'b0; clr_req = 1'b0;
        set_rd(2'b11, 5'd5, 5'd6);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, busy_a}, 32'h1);
        chk("reset_done", {31'h0, done_a}, 32'h0);
        chk("reset_rd", rd_a[31:0], 32'h0);

        tick();
        rst = 1'b1;
        count_clear("initclr");
        for (int a = 1; a < 32; a++) begin
            set_rd(2'b11, 5'(a), 5'(a));
            @(negedge clk);
            chk("initclr_read", rd_a[31:0], 32'h0);
        end
        tick();

        set_rd(2'b11, 5'd5, 5'd5);
        set_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        @(negedge clk);
        chk("byp_a_p0", rd_a[31:0],  32'hDEADBEEF);
        chk("byp_a_p1", rd_a[63:32], 32'hDEADBEEF);
        chk("nobyp_b_p0", rd_b[31:0], 32'h0);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        chk("stored_b_p0", rd_b[31:0],  32'hDEADBEEF);
        chk("stored_b_p1", rd_b[63:32], 32'hDEADBEEF);
        tick();

        set_rd(2'b10, 5'd5, 5'd5);
        @(negedge clk);
        chk("rden_off", rd_a[31:0], 32'h0);
        chk("rden_on", rd_a[63:32], 32'hDEADBEEF);
        tick();

        set_rd(2'b11, 5'd7, 5'd7);
        set_wr(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222);
        @(negedge clk);
        chk("conflict_byp", rd_a[31:0], 32'h22222222);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        chk("conflict_a", rd_a[63:32], 32'h22222222);
        chk("conflict_b", rd_b[31:0],  32'h22222222);
        tick();

        set_rd(2'b11, 5'd0, 5'd0);
        set_wr(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        chk("r0_zero", rd_a[31:0], 32'h0);
        chk("r0_plain", rd_b[31:0], 32'h12345678);
        tick();

        clr_req = 1'b1;
        @(negedge clk);
        chk("busy_before_req", {31'h0, busy_a}, 32'h0);
        tick();
        clr_req = 1'b0;
        set_wr(2'b01, 5'd9, 32'h99999999, 5'd0, 32'h0);
        @(negedge clk);
        chk("busy_after_req", {31'h0, busy_a}, 32'h1);
        repeat (10) tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        count_clear("restart");
        set_rd(2'b11, 5'd9, 5'd5);
        @(negedge clk);
        chk("restart_r9", rd_a[31:0], 32'h0);
        chk("restart_r5", rd_b[63:32], 32'h0);
        tick();

        set_rd(2'b11, 5'd3, 5'd3);
        set_wr(2'b01, 5'd3, 32'h33333333, 5'd0, 32'h0);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        chk("r3_written", rd_a[31:0], 32'h33333333);
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        set_wr(2'b01, 5'd3, 32'hBADBAD00, 5'd0, 32'h0);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", {31'h0, busy_a}, 32'h1);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        rst = 1'b1;
        count_clear("rstclr");
        @(negedge clk);
        chk("r3_cleared_a", rd_a[31:0], 32'h0);
        chk("r3_cleared_b", rd_b[63:32], 32'h0);
        tick();

        set_rd(2'b11, 5'd4, 5'd4);
        set_wr(2'b10, 5'd0, 32'h0, 5'd4, 32'h44444444);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        chk("r4_written", rd_b[31:0], 32'h44444444);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_idle_busy", {31'h0, busy_a}, 32'h1);
        chk("rst_idle_rd", rd_a[31:0], 32'h0);
        tick();
        rst = 1'b1;
        count_clear("idlerst");
        @(negedge clk);
        chk("r4_cleared", rd_b[31:0], 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
